// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 16 B, 128-bit block refills.
// Hits are served combinationally; misses stall the pipeline through busywait.
module dcache_controller (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   mem_read,
   input  logic [2:0]   mem_write,
   input  logic [31:0]  address,
   input  logic [31:0]  write_data,
   output logic [31:0]  read_data,
   output logic         busywait,
   output logic         mem_rd,
   output logic         mem_wr,
   output logic [27:0]  mem_address,
   output logic [127:0] mem_writedata,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t state, next_state;

   logic [7:0]   valid, dirty;
   logic [24:0]  tag_array  [8];
   logic [127:0] data_array [8];

   logic [24:0]  tag;
   logic [2:0]   index;
   logic [1:0]   word_sel, byte_sel;
   logic         active, hit, store_hit, fill;
   logic [127:0] line, store_line;
   logic [31:0]  word;

   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                               input logic [1:0] f, input logic [1:0] off);
      logic [31:0] r;
      r = w;
      case (f)
         2'b00:   r[{off, 3'b000} +: 8]  = wd[7:0];
         2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   assign {tag, index, word_sel, byte_sel} = address;

   // A store takes precedence when both enables are set, so either enable makes the request active.
   assign active    = mem_read[3] | mem_write[2];
   assign hit       = valid[index] && (tag_array[index] == tag);
   assign store_hit = (state == IDLE) && mem_write[2] && hit;
   assign fill      = (state == ALLOCATE) && !mem_busywait && !rst;

   assign line      = data_array[index];
   assign word      = line[{word_sel, 5'b00000} +: 32];
   assign read_data = load_extract(word, mem_read[2:0], byte_sel);

   always_comb begin
      store_line = line;
      store_line[{word_sel, 5'b00000} +: 32] = store_merge(word, write_data, mem_write[1:0], byte_sel);
   end

   always_comb begin
      next_state    = state;
      busywait      = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      case (state)
         IDLE: begin
            if (active && !hit) begin
               busywait   = 1'b1;
               next_state = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            busywait      = 1'b1;
            mem_wr        = 1'b1;
            mem_address   = {tag_array[index], index};
            mem_writedata = line;
            if (!mem_busywait) next_state = ALLOCATE;
         end
         ALLOCATE: begin
            busywait    = 1'b1;
            mem_rd      = 1'b1;
            mem_address = address[31:4];
            if (!mem_busywait) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill) begin
         valid[index] <= 1'b1;
         dirty[index] <= 1'b0;
      end else if (store_hit) begin
         dirty[index] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_array[index]  <= tag;
         data_array[index] <= mem_readdata;
      end else if (store_hit) begin
         data_array[index] <= store_line;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller: a flat block-memory golden view plus a tag/valid/dirty
// model predicts load data, hit/miss/writeback behaviour and stall lengths.
module tb_dcache_controller;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   mem_read;
   logic [2:0]   mem_write;
   logic [31:0]  address;
   logic [31:0]  write_data;
   logic [31:0]  read_data;
   logic         busywait;
   logic         mem_rd;
   logic         mem_wr;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   always #5 clk = ~clk;

   dcache_controller dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .address(address),
      .write_data(write_data), .read_data(read_data), .busywait(busywait), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   int checks = 0;
   int failures = 0;

   logic [127:0] mem_blk  [int];
   logic [127:0] gold_blk [int];
   bit           m_valid [8];
   bit           m_dirty [8];
   logic [24:0]  m_tag   [8];

   int           lat_cnt = 0, lat_tgt = 0, mem_sum = 0, n_wb = 0, n_rd = 0, last_stall = 0;
   logic [27:0]  exp_rd_addr, exp_wb_addr;
   logic [127:0] last_wb_data;
   logic         s_bw, s_mem_rd, s_mem_wr, first_mem_rd;
   logic [31:0]  s_rd, last_rd;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] init_blk(input logic [27:0] ba);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) b[i*32 +: 32] = 32'h9E37_79B1 * (32'(ba) * 4 + i + 1);
      return b;
   endfunction

   function automatic logic [127:0] mem_get(input logic [27:0] ba);
      return mem_blk.exists(int'(ba)) ? mem_blk[int'(ba)] : init_blk(ba);
   endfunction

   function automatic logic [127:0] gold_get(input logic [27:0] ba);
      return gold_blk.exists(int'(ba)) ? gold_blk[int'(ba)] : init_blk(ba);
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
      logic [127:0] blk;
      logic [31:0]  w;
      logic [7:0]   b;
      logic [15:0]  h;
      blk = gold_get(a[31:4]);
      w = blk[a[3:2]*32 +: 32];
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      case (f3)
         3'b000:  return 32'($signed(b));
         3'b001:  return 32'($signed(h));
         3'b100:  return 32'(b);
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   task automatic gold_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] f);
      logic [127:0] blk;
      int n, off;
      blk = gold_get(a[31:4]);
      case (f)
         2'b00:   begin n = 1; off = int'(a[1:0]); end
         2'b01:   begin n = 2; off = a[1] ? 2 : 0; end
         default: begin n = 4; off = 0; end
      endcase
      for (int i = 0; i < n; i++) blk[(int'(a[3:2]) * 4 + off + i) * 8 +: 8] = wd[i*8 +: 8];
      gold_blk[int'(a[31:4])] = blk;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      gold_blk = mem_blk;
   endtask

   // One clock cycle: entered 1 time unit after a posedge, leaves 1 time unit after the next one.
   task automatic step();
      logic         was_req, was_wr, done;
      logic [27:0]  a;
      logic [127:0] wd;
      #1;
      was_req = mem_rd | mem_wr;
      if (was_req) mem_busywait = (lat_cnt < lat_tgt);
      else         mem_busywait = 1'($urandom);
      mem_readdata = mem_rd ? mem_get(mem_address) : {$urandom, $urandom, $urandom, $urandom};
      #1;
      s_bw = busywait; s_rd = read_data; s_mem_rd = mem_rd; s_mem_wr = mem_wr;
      if (was_req) chk("rd_wr_excl", mem_rd & mem_wr, 1'b0);
      done = was_req && !mem_busywait;
      was_wr = mem_wr; a = mem_address; wd = mem_writedata;
      if (done && !rst) begin
         if (was_wr) begin
            chk("wb_addr", a, exp_wb_addr);
            chk("wb_data", wd, gold_get(a));
            last_wb_data = wd;
         end else begin
            chk("rd_addr", a, exp_rd_addr);
         end
      end
      @(posedge clk);
      #1;
      if (was_req) begin
         if (done) begin
            if (!rst) begin
               if (was_wr) begin
                  mem_blk[int'(a)] = wd;
                  n_wb++;
               end else begin
                  n_rd++;
               end
               mem_sum += lat_tgt + 1;
            end
            lat_cnt = 0;
            lat_tgt = $urandom_range(0, 3);
         end else begin
            lat_cnt++;
         end
      end
   endtask

   task automatic access(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a,
                         input logic [31:0] wd);
      int idx, stall;
      bit exp_hit, exp_wb, fin;
      idx = int'(a[6:4]);
      exp_hit = m_valid[idx] && (m_tag[idx] == a[31:7]);
      exp_wb = !exp_hit && m_valid[idx] && m_dirty[idx];
      exp_wb_addr = {m_tag[idx], a[6:4]};
      exp_rd_addr = a[31:4];
      mem_read = mr; mem_write = mw; address = a; write_data = wd;
      mem_sum = 0; n_wb = 0; n_rd = 0; stall = 0; fin = 1'b0;
      for (int c = 0; c < 64; c++) begin
         step();
         if (c == 0) first_mem_rd = s_mem_rd;
         if (!s_bw) begin
            fin = 1'b1;
            break;
         end
         stall++;
      end
      chk("finish", fin, 1'b1);
      chk("stall", stall, exp_hit ? 0 : 1 + mem_sum);
      chk("n_wb", n_wb, exp_wb);
      chk("n_rd", n_rd, !exp_hit);
      if (!mw[2] && mr[3]) chk("load", s_rd, exp_load(a, mr[2:0]));
      last_rd = s_rd;
      last_stall = stall;
      if (!exp_hit) begin
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx] = a[31:7];
      end
      if (mw[2]) begin
         m_dirty[idx] = 1'b1;
         gold_store(a, wd, mw[1:0]);
      end
      mem_read = '0;
      mem_write = '0;
   endtask

   initial begin
      logic [127:0] seed;
      logic [2:0]   lf [5];
      logic [31:0]  ra;
      int           r;
      lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      rst = 1'b1; mem_read = '0; mem_write = '0; address = '0; write_data = '0;
      mem_readdata = '0; mem_busywait = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_busywait", busywait, 1'b0);
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_mem_address", mem_address, 28'h0);
      chk("rst_mem_writedata", mem_writedata, 128'h0);
      @(posedge clk);
      #1;

      // Cold miss with a 3-cycle memory, then hits and sub-word stores on the same line.
      seed = init_blk(28'h4);
      seed[31:0] = 32'hDEAD_BEEF;
      mem_blk[4] = seed;
      gold_blk[4] = seed;
      lat_cnt = 0; lat_tgt = 2;
      access(4'b1010, 3'b000, 32'h40, 32'h0);
      chk("lw40_data", last_rd, 32'hDEAD_BEEF);
      chk("lw40_stall", last_stall, 4);
      access(4'b1010, 3'b000, 32'h44, 32'h0);
      chk("lw44_stall", last_stall, 0);
      access(4'b0000, 3'b100, 32'h41, 32'h80);
      access(4'b1000, 3'b000, 32'h41, 32'h0);
      chk("lb41", last_rd, 32'hFFFF_FF80);
      access(4'b1100, 3'b000, 32'h41, 32'h0);
      chk("lbu41", last_rd, 32'h0000_0080);

      // Dirty eviction of line 4.
      access(4'b1010, 3'b000, 32'hC0, 32'h0);
      chk("wb_byte", last_wb_data[15:8], 8'h80);

      access(4'b0000, 3'b101, 32'h102, 32'h1234);
      access(4'b1001, 3'b000, 32'h102, 32'h0);
      chk("lh102", last_rd, 32'h0000_1234);
      access(4'b1101, 3'b000, 32'h102, 32'h0);
      chk("lhu102", last_rd, 32'h0000_1234);
      access(4'b0000, 3'b101, 32'h102, 32'h0000_F00D);
      access(4'b1001, 3'b000, 32'h102, 32'h0);
      chk("lh102_neg", last_rd, 32'hFFFF_F00D);

      // Reset during ALLOCATE, coinciding with the memory completion.
      mem_read = 4'b1010; address = 32'h250; exp_rd_addr = 28'h25;
      lat_cnt = 0; lat_tgt = 5;
      step();
      chk("miss_bw", s_bw, 1'b1);
      step();
      chk("alloc_mem_rd", s_mem_rd, 1'b1);
      lat_cnt = lat_tgt;
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      access(4'b1010, 3'b000, 32'h250, 32'h0);
      chk("post_rst_mem_rd", first_mem_rd, 1'b0);
      chk("post_rst_remiss", last_stall > 0, 1'b1);

      // Idle cycles with noise on the address and memory bus.
      for (int i = 0; i < 8; i++) begin
         mem_read = '0; mem_write = '0; address = $urandom; write_data = $urandom;
         step();
         chk("idle_bw", s_bw, 1'b0);
         chk("idle_mem_rd", s_mem_rd, 1'b0);
         chk("idle_mem_wr", s_mem_wr, 1'b0);
      end

      for (int i = 0; i < 400; i++) begin
         ra = {23'h0, 2'($urandom_range(0, 3)), 3'($urandom), 2'($urandom), 2'($urandom)};
         r = $urandom_range(0, 9);
         if (r < 4)
            access(4'b0000, {1'b1, 2'($urandom_range(0, 2))}, ra, $urandom);
         else if (r == 4)
            access({1'b1, lf[$urandom_range(0, 4)]}, {1'b1, 2'($urandom_range(0, 2))}, ra, $urandom);
         else
            access({1'b1, lf[$urandom_range(0, 4)]}, 3'b000, ra, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache of the RV32IM pipeline, sitting in the MEM stage between the pipeline and main data memory. It services the load/store requests that the pipeline carries down through its stage registers (`mem_read`/`mem_write` encodings) and produces the `busywait` signal that freezes every pipeline register while a miss is in progress. Geometry is 8 lines × 16 B (4 words), with 128-bit block transfers to main memory.

## Interface
- (no parameters) — geometry fixed: 8 lines, 16 B/line, 25-bit tag, address split tag[31:7] | index[6:4] | word[3:2] | byte[1:0].

Ports:
- `clk  in  1` — single clock; everything is sampled on the rising edge.
- `rst  in  1` — synchronous, active-high reset.
- `mem_read  in  4` — bit3 = load enable; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `mem_write  in  3` — bit2 = store enable; [1:0] = funct3[1:0] (00 SB, 01 SH, 10 SW).
- `address  in  32` — byte address from the ALU result.
- `write_data  in  32` — store data, right-aligned.
- `read_data  out  32` — load result, sign- or zero-extended.
- `busywait  out  1` — high = stall the pipeline.
- `mem_rd  out  1` — main-memory block read request.
- `mem_wr  out  1` — main-memory block write request.
- `mem_address  out  28` — block address (byte address [31:4]).
- `mem_writedata  out  128` — evicted block, word0 in [31:0].
- `mem_readdata  in  128` — fetched block, word0 in [31:0].
- `mem_busywait  in  1` — main memory is busy; a request completes on the first posedge it samples 0.

## Operation
- Per line: valid, dirty, tag[24:0], data[127:0]. Hit = valid && tag match at the indexed line.
- The request is active when `mem_read[3]` or `mem_write[2]` is set. If both are set, the store wins and the load is ignored.
- FSM states and transitions:
  - IDLE:
    - Active request and hit: serve it; stay in IDLE.
    - Active request, miss, clean or invalid victim: go to ALLOCATE.
    - Active request, miss, dirty victim: go to WRITEBACK.
  - WRITEBACK:
    - `mem_wr`=1, `mem_address`={victim tag, index}, `mem_writedata`=victim data.
    - When `mem_busywait`=0 is sampled, go to ALLOCATE.
  - ALLOCATE:
    - `mem_rd`=1, `mem_address`=address[31:4].
    - When `mem_busywait`=0 is sampled: write `mem_readdata` into the line; set valid=1, dirty=0, tag=address[31:7]; go to IDLE.
- `busywait`, combinational:
  - 1 when in WRITEBACK or ALLOCATE.
  - 1 when in IDLE with an active request that misses.
  - 0 otherwise, including when there is no request.
- Load hit, combinational from the array:
  - LB/LBU select the byte at address[1:0]; LB sign-extends, LBU zero-extends.
  - LH/LHU select the halfword at address[1]; address[0] is ignored.
  - LW: address[1:0] is ignored.
- Store hit: at the posedge, update only the addressed byte, halfword or word of the line and set dirty=1.
- With no active request, `read_data` still shows the addressed word but has no meaning.
- Memory requests are held stable (address and data) until completion. `mem_rd` and `mem_wr` are never high together.

## Timing
- Reset values: FSM=IDLE; all valid=0 and dirty=0; `mem_rd`=0, `mem_wr`=0, `mem_address`=0, `mem_writedata`=0. `busywait` reads 0 unless a request is presented.
- Tag and data contents are not reset.
- Hit latency is 0 cycles: `busywait` stays low and the pipeline register latches `read_data` at the same posedge that commits a store.
- Miss, clean victim: busywait rises combinationally in the request cycle.
  - At posedge 1 the FSM enters ALLOCATE.
  - The fill completes at the first posedge with `mem_busywait`=0 (k cycles).
  - The next cycle is IDLE with a hit, so busywait drops.
  - Total stall = 1 + k cycles, with k ≥ 1.
- Miss, dirty victim: adds the WRITEBACK wait w ≥ 1 cycles before ALLOCATE.
- The pipeline holds `mem_read`, `mem_write`, `address` and `write_data` stable while busywait=1. The controller relies on this and does not latch them.
- Reset mid-miss: the next state is IDLE, requests drop at once, and the line being filled or evicted is lost because all valid bits clear.
- A memory completion that coincides with `rst`=1 is discarded.

## Test plan
- Reset, then LW at 0x0000_0040 → busywait=1 in cycle 0 and `mem_rd`=1 with `mem_address`=0x000_0004. Memory responds after 3 cycles with word0=0xDEAD_BEEF → busywait low in the following cycle and `read_data`=0xDEAD_BEEF. An immediate second LW to 0x44 hits with no stall.
- After that fill, SB 0x80 to 0x41 then LB 0x41 → read_data=0xFFFF_FF80, and LBU 0x41 → 0x0000_0080. Both accesses hit, and the line is dirty.
- LW at 0x0000_00C0 (same index, new tag) → WRITEBACK with `mem_wr`=1, `mem_address`=0x000_0004, and `mem_writedata` containing the modified byte. This is followed by ALLOCATE at 0x000_000C; the total stall equals 1 + w + k cycles.
- SH 0x1234 to 0x102, then LH/LHU 0x102 → 0x0000_1234. Then SH 0xF00D and LH → 0xFFFF_F00D.
- `rst` asserted during ALLOCATE → next cycle FSM=IDLE with `mem_rd`=0. Re-issuing the same LW misses again.
- No request, with random address and `mem_readdata` values → busywait=0, `mem_rd`=`mem_wr`=0, and no line state changes.
